// File: rtl/ball_move_if.sv
// ball_move_if: frame/hit/launch controls into ball_move and the ball
// position/direction/draw strobe out of it.
//   master : whoever drives the controls (game controller, bench)
//   slave  : ball_move itself
interface ball_move_if;
   logic       enable;
   logic       frame_tick;
   logic       brick_hit_x;
   logic       brick_hit_y;
   logic       paddle_hit;
   logic       launch;
   logic [9:0] x_out;
   logic [9:0] y_out;
   logic       go;
   logic       dir_x;
   logic       dir_y;
   logic       dead;

   modport master (
      output enable, frame_tick, brick_hit_x, brick_hit_y, paddle_hit, launch,
      input  x_out, y_out, go, dir_x, dir_y, dead
   );

   modport slave (
      input  enable, frame_tick, brick_hit_x, brick_hit_y, paddle_hit, launch,
      output x_out, y_out, go, dir_x, dir_y, dead
   );
endinterface

// File: rtl/ball_move.sv
// ball_move: owns the ball position/direction. On each enabled frame tick it
// steps the ball, applies wall/brick/paddle bounces, then strobes go for one
// cycle so ball_draw can latch the new (x,y). Ball loss at the bottom parks
// the FSM in S_DEAD until launch.
// Build option: define BALL_FAST_EN for a 2-pixel step per axis per move.
// Note: resetn is active-HIGH and asynchronous.
module ball_move #(
   parameter int X_MAX   = 160,
   parameter int Y_MAX   = 120,
   parameter int X_START = 80,
   parameter int Y_START = 100
) (
   input  logic        clk,
   input  logic        resetn,
   ball_move_if.slave  bus
);

`ifdef BALL_FAST_EN
   localparam int STEP = 2;
`else
   localparam int STEP = 1;
`endif

   // Edge zones: within one step of a wall the next move must head inward.
   localparam logic [9:0] X_HI  = 10'(X_MAX - STEP);
   localparam logic [9:0] Y_HI  = 10'(Y_MAX - STEP);
   localparam logic [9:0] LO    = 10'(STEP - 1);
   localparam logic [9:0] STP   = 10'(STEP);
   localparam logic [9:0] X_RST = 10'(X_START);
   localparam logic [9:0] Y_RST = 10'(Y_START);

   typedef enum logic [1:0] {S_WAIT, S_MOVE, S_DRAW, S_DEAD} state_t;

   state_t     state;
   logic       hit_x, hit_y, pad_f;
   logic       at_right, at_left, at_top, at_bot;
   logic       wall_x, top, bottom, lost;
   logic       nx_dir, ny_dir;
   logic [9:0] nx_pos, ny_pos;

   // Next direction/position for the S_MOVE cycle.
   always_comb begin
      at_right = bus.x_out >= X_HI;
      at_left  = bus.x_out <= LO;
      at_bot   = bus.y_out >= Y_HI;
      at_top   = bus.y_out <= LO;

      // A brick flip and a wall flip together flip once (OR, not XOR twice).
      wall_x = bus.dir_x ? at_right : at_left;
      nx_dir = bus.dir_x ^ (hit_x | wall_x);
      // A brick flip that would point into an adjacent wall is overridden so
      // the ball never leaves the screen.
      if (at_right)     nx_dir = 1'b0;
      else if (at_left) nx_dir = 1'b1;

      top    = ~bus.dir_y & at_top;
      bottom = bus.dir_y & at_bot;
      lost   = bottom & ~pad_f;
      ny_dir = bus.dir_y ^ (hit_y | top);
      if (bottom)       ny_dir = 1'b0;
      else if (at_top)  ny_dir = 1'b1;
      else if (at_bot)  ny_dir = 1'b0;

      nx_pos = nx_dir ? bus.x_out + STP : bus.x_out - STP;
      ny_pos = ny_dir ? bus.y_out + STP : bus.y_out - STP;
   end

   // Ball FSM with sticky hit flags and registered outputs.
   always_ff @(posedge clk or posedge resetn) begin
      if (resetn) begin
         state     <= S_WAIT;
         bus.x_out <= X_RST;
         bus.y_out <= Y_RST;
         bus.dir_x <= 1'b1;
         bus.dir_y <= 1'b0;
         bus.go    <= 1'b0;
         bus.dead  <= 1'b0;
         hit_x     <= 1'b0;
         hit_y     <= 1'b0;
         pad_f     <= 1'b0;
      end else begin
         // Hit pulses are captured on any cycle until a move consumes them.
         hit_x  <= hit_x | bus.brick_hit_x;
         hit_y  <= hit_y | bus.brick_hit_y;
         pad_f  <= pad_f | bus.paddle_hit;
         bus.go <= 1'b0;
         case (state)
            S_WAIT: begin
               if (bus.frame_tick && bus.enable) state <= S_MOVE;
            end
            S_MOVE: begin
               // Consume the flags, but keep pulses arriving this very cycle.
               hit_x <= bus.brick_hit_x;
               hit_y <= bus.brick_hit_y;
               pad_f <= bus.paddle_hit;
               if (lost) begin
                  bus.dead <= 1'b1;
                  state    <= S_DEAD;
               end else begin
                  bus.dir_x <= nx_dir;
                  bus.dir_y <= ny_dir;
                  bus.x_out <= nx_pos;
                  bus.y_out <= ny_pos;
                  bus.go    <= 1'b1;
                  state     <= S_DRAW;
               end
            end
            S_DRAW: begin
               state <= S_WAIT;
            end
            S_DEAD: begin
               if (bus.launch) begin
                  bus.x_out <= X_RST;
                  bus.y_out <= Y_RST;
                  bus.dir_x <= 1'b1;
                  bus.dir_y <= 1'b0;
                  bus.dead  <= 1'b0;
                  bus.go    <= 1'b1;
                  hit_x     <= 1'b0;
                  hit_y     <= 1'b0;
                  pad_f     <= 1'b0;
                  state     <= S_DRAW;
               end
            end
            default: state <= S_WAIT;
         endcase
      end
   end

endmodule

// File: tb/tb_ball_move.sv
// Bench for ball_move (default 1-pixel build): hand-computed vector table
// plus corner sequences; every go pulse is checked against a queue of
// expected positions.
module tb_ball_move;
   localparam int X_MAX = 160;
   localparam int Y_MAX = 120;

   logic clk = 1'b0;
   logic resetn;
   ball_move_if bus ();

   ball_move #(.X_MAX(X_MAX), .Y_MAX(Y_MAX), .X_START(80), .Y_START(100))
      dut (.clk(clk), .resetn(resetn), .bus(bus));

   always #5 clk = ~clk;

   typedef struct {int x; int y; bit dx; bit dy;} exp_t;
   typedef struct {bit bx; bit by; int ex; int ey; bit edx; bit edy;} vec_t;

   exp_t q[$];
   int   tests = 0;
   int   fails = 0;
   int   mx, my;
   bit   mdx, mdy;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard: every go must match the oldest expected position.
   always @(negedge clk) begin
      if (bus.go === 1'b1) begin
         if (q.size() == 0) begin
            chk("unexpected_go", 1, 0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("go_x", int'(bus.x_out), e.x);
            chk("go_y", int'(bus.y_out), e.y);
            chk("go_dx", int'(bus.dir_x), int'(e.dx));
            chk("go_dy", int'(bus.dir_y), int'(e.dy));
         end
      end
   end

   function automatic void model_reset();
      mx = 80; my = 100; mdx = 1'b1; mdy = 1'b0;
   endfunction

   // Reference move: OR-combined flips, paddle/death at the bottom row.
   function automatic void model(input bit bx, input bit by, input bit pd,
                                 output exp_t e, output bit die);
      bit wx, ndx, ndy;
      die = 1'b0;
      wx  = mdx ? (mx == X_MAX-1) : (mx == 0);
      ndx = mdx ^ (bx | wx);
      if (mdy && my == Y_MAX-1) begin
         die = !pd;
         ndy = 1'b0;
      end else begin
         ndy = mdy ^ (by | (!mdy && my == 0));
      end
      if (!die) begin
         mx  = ndx ? mx + 1 : mx - 1;
         my  = ndy ? my + 1 : my - 1;
         mdx = ndx;
         mdy = ndy;
      end
      e = '{mx, my, mdx, mdy};
   endfunction

   task automatic pulse_tick();
      @(posedge clk); #1 bus.frame_tick = 1'b1;
      @(posedge clk); #1 bus.frame_tick = 1'b0;
   endtask

   // Bounded wait for all expected go pulses, then let the FSM settle.
   task automatic drain();
      for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
      chk("go_pending", q.size(), 0);
      q.delete();
      repeat (2) @(posedge clk);
   endtask

   task automatic pulse_hits(input bit bx, input bit by, input bit pd);
      @(posedge clk); #1;
      bus.brick_hit_x = bx; bus.brick_hit_y = by; bus.paddle_hit = pd;
      @(posedge clk); #1;
      bus.brick_hit_x = 1'b0; bus.brick_hit_y = 1'b0; bus.paddle_hit = 1'b0;
      repeat (3) @(posedge clk);
   endtask

   task automatic do_tick(input bit bx, input bit by, input bit pd, output bit died);
      exp_t e;
      bit   die;
      model(bx, by, pd, e, die);
      if (bx | by | pd) pulse_hits(bx, by, pd);
      if (!die) q.push_back(e);
      pulse_tick();
      drain();
      died = die;
   endtask

   vec_t tbl[5];

   initial begin
      bit d;
      exp_t e;
      // Hand-computed from reset (80,100, right, up).
      tbl[0] = '{0, 0, 81, 99, 1'b1, 1'b0};
      tbl[1] = '{1, 0, 80, 98, 1'b0, 1'b0};
      tbl[2] = '{0, 1, 79, 99, 1'b0, 1'b1};
      tbl[3] = '{1, 1, 80, 98, 1'b1, 1'b0};
      tbl[4] = '{0, 0, 81, 97, 1'b1, 1'b0};

      resetn = 1'b1;
      bus.enable = 1'b0; bus.frame_tick = 1'b0; bus.launch = 1'b0;
      bus.brick_hit_x = 1'b0; bus.brick_hit_y = 1'b0; bus.paddle_hit = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_x", int'(bus.x_out), 80);
      chk("rst_y", int'(bus.y_out), 100);
      chk("rst_dx", int'(bus.dir_x), 1);
      chk("rst_dy", int'(bus.dir_y), 0);
      chk("rst_go", int'(bus.go), 0);
      chk("rst_dead", int'(bus.dead), 0);
      resetn = 1'b0;
      bus.enable = 1'b1;
      model_reset();

      // Vector table.
      for (int i = 0; i < 5; i++) begin
         if (tbl[i].bx | tbl[i].by) pulse_hits(tbl[i].bx, tbl[i].by, 1'b0);
         q.push_back('{tbl[i].ex, tbl[i].ey, tbl[i].edx, tbl[i].edy});
         pulse_tick();
         if (i == 0) begin
            @(negedge clk); chk("lat_t1_go", int'(bus.go), 0);
            @(negedge clk); chk("lat_t2_go", int'(bus.go), 1);
            @(negedge clk); chk("lat_t3_go", int'(bus.go), 0);
         end
         drain();
         mx = tbl[i].ex; my = tbl[i].ey; mdx = tbl[i].edx; mdy = tbl[i].edy;
      end

      // Right wall with a simultaneous brick flip: single flip.
      for (int n = 0; n < 400 && !(mx == X_MAX-1 && mdx); n++) do_tick(0, 0, 0, d);
      do_tick(1, 0, 0, d);
      chk("wall_brick_x", int'(bus.x_out), 158);
      chk("wall_brick_dx", int'(bus.dir_x), 0);

      // Bottom row with paddle latched five cycles before the tick.
      for (int n = 0; n < 600 && !(my == Y_MAX-1 && mdy); n++) do_tick(0, 0, 0, d);
      chk("pre_pad_y", int'(bus.y_out), 119);
      do_tick(0, 0, 1, d);
      chk("paddle_y", int'(bus.y_out), 118);
      chk("paddle_dy", int'(bus.dir_y), 0);

      // Bottom row without paddle: ball lost, no go, position held.
      for (int n = 0; n < 600 && !(my == Y_MAX-1 && mdy); n++) do_tick(0, 0, 0, d);
      do_tick(0, 0, 0, d);
      chk("dead_model", int'(d), 1);
      chk("dead_flag", int'(bus.dead), 1);
      chk("dead_y", int'(bus.y_out), 119);
      chk("dead_x", int'(bus.x_out), mx);
      pulse_tick();
      repeat (5) @(posedge clk);
      chk("dead_tick_y", int'(bus.y_out), 119);
      chk("dead_tick_flag", int'(bus.dead), 1);
      q.push_back('{80, 100, 1'b1, 1'b0});
      @(posedge clk); #1 bus.launch = 1'b1;
      @(posedge clk); #1 bus.launch = 1'b0;
      drain();
      model_reset();
      chk("launch_dead", int'(bus.dead), 0);
      chk("launch_x", int'(bus.x_out), 80);

      // Ticks on two consecutive cycles: one move, one go.
      model(0, 0, 0, e, d);
      q.push_back(e);
      @(posedge clk); #1 bus.frame_tick = 1'b1;
      @(posedge clk);
      @(posedge clk); #1 bus.frame_tick = 1'b0;
      drain();
      repeat (4) @(posedge clk);
      chk("dbl_x", int'(bus.x_out), 81);
      chk("dbl_y", int'(bus.y_out), 99);

      // enable low: tick ignored.
      bus.enable = 1'b0;
      pulse_tick();
      repeat (5) @(posedge clk);
      chk("dis_x", int'(bus.x_out), 81);
      chk("dis_y", int'(bus.y_out), 99);
      bus.enable = 1'b1;

      // Reset asserted while go is high.
      pulse_tick();
      @(posedge clk); #1;
      chk("pre_rst_go", int'(bus.go), 1);
      #1 resetn = 1'b1;
      #1;
      chk("mid_rst_go", int'(bus.go), 0);
      chk("mid_rst_x", int'(bus.x_out), 80);
      chk("mid_rst_y", int'(bus.y_out), 100);
      chk("mid_rst_dx", int'(bus.dir_x), 1);
      chk("mid_rst_dy", int'(bus.dir_y), 0);
      @(posedge clk); #1 resetn = 1'b0;
      repeat (4) @(posedge clk);
      chk("post_rst_go", int'(bus.go), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/ball_move.md
Name: ball_move

Overview:
- Upstream stage of ball_draw: owns ball position and direction.
- On each frame tick it steps the ball one pixel per axis and applies wall, brick and paddle bounces.
- It then emits the new (x,y) with a one-cycle go pulse that ball_draw registers and forwards to the VGA adapter.
- It detects ball loss at the bottom edge and holds until a relaunch.

Parameters:
- X_MAX, 160, screen width in pixels; legal x is 0..X_MAX-1.
- Y_MAX, 120, screen height in pixels; legal y is 0..Y_MAX-1.
- X_START, 80, launch/reset x.
- Y_START, 100, launch/reset y.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous reset, active-HIGH (named per codebase convention; asserted = 1)
- enable  in  1  when 0, frame ticks are ignored
- frame_tick  in  1  one-cycle pulse per frame
- brick_hit_x  in  1  pulse; flip x direction at next move
- brick_hit_y  in  1  pulse; flip y direction at next move
- paddle_hit  in  1  pulse; ball is over the paddle on bottom row
- launch  in  1  pulse; restart from DEAD
- x_out  out  10  ball x, to ball_draw x_in
- y_out  out  10  ball y, to ball_draw y_in
- go  out  1  one-cycle draw strobe, to ball_draw go
- dir_x  out  1  1 = right, 0 = left
- dir_y  out  1  1 = down, 0 = up
- dead  out  1  ball lost; high while in S_DEAD

Behaviour:
- Reset (async, resetn=1) values:
  - x_out=X_START, y_out=Y_START
  - dir_x=1, dir_y=0
  - go=0, dead=0
  - all hit latches 0
  - state S_WAIT
- Hit latches:
  - Each of brick_hit_x, brick_hit_y and paddle_hit sets a sticky flag on any cycle.
  - Flags are cleared in S_MOVE after use.
  - A pulse arriving during S_MOVE is kept for the next move, not lost.
- FSM states: S_WAIT, S_MOVE, S_DRAW, S_DEAD.
  - S_WAIT:
    - frame_tick=1 and enable=1 -> S_MOVE.
    - Otherwise stay; the tick is dropped, not queued.
  - S_MOVE, one cycle; compute the new directions, then the new position:
    - nx_dir = dir_x XOR (hit_x_flag OR wall_x). wall_x = (dir_x=1 and x_out=X_MAX-1) or (dir_x=0 and x_out=0). A brick flip and a wall flip in the same move flip once only (OR, not double-XOR).
    - ny_dir = dir_y XOR (hit_y_flag OR top), where top = (dir_y=0 and y_out=0).
    - Bottom edge, dir_y=1 and y_out=Y_MAX-1:
      - paddle_flag=1 -> ny_dir=0 (up).
      - paddle_flag=0 -> go to S_DEAD; position unchanged; no go pulse.
    - paddle_flag has no effect while dir_y=0.
    - Position: x_out <= x_out+1 if nx_dir else x_out-1; same rule for y_out with ny_dir. The result always stays within 0..MAX-1.
    - Then -> S_DRAW.
  - S_DRAW: go=1 for exactly this one cycle, with x_out/y_out already holding the new values; -> S_WAIT.
  - S_DEAD:
    - dead=1; frame ticks ignored.
    - launch=1 -> x_out=X_START, y_out=Y_START, dir_x=1, dir_y=0, flags cleared, then -> S_DRAW (a single go pulse redraws the ball).
- Latency: tick sampled at cycle T; position updates at T+1 edge; go=1 during T+2; back in S_WAIT at T+3. Ticks arriving at T+1 or T+2 are dropped.
- The minimum tick spacing for no drops is 3 cycles.
- launch outside S_DEAD is ignored.
- Reset mid-operation: immediate return to reset values. A go pulse in flight is killed the same cycle.
- x_out/y_out change only in S_MOVE and at launch/reset; they are stable while go=1.

Optional Feature:
- BALL_FAST_EN:
  - Defined: step is 2 pixels per axis per move.
  - Wall detection uses x_out>=X_MAX-2 (right) and x_out<=1 (left); same rule for y. On a bounce the ball reflects toward the interior. Example: x_out=158, dir right -> x_out=156, dir left.
  - Bottom/paddle check uses y_out>=Y_MAX-2.
- Undefined: 1-pixel step exactly as above.

Test Plan:
- Reset, then enable=1 and one frame_tick -> go pulse 2 cycles after the tick; x_out=81, y_out=99, dir_x=1, dir_y=0.
- Preload via repeated ticks to x_out=159 moving right, then tick -> x_out=158, dir_x=0; an accompanying brick_hit_x in the same frame still yields a single flip (dir_x=0).
- Ball at y_out=119 moving down, paddle_hit pulsed 5 cycles before the tick -> y_out=118, dir_y=0, go pulses.
- Ball at y_out=119 moving down, no paddle_hit, tick -> dead=1, no go, position held; further ticks ignored; launch -> x_out=80, y_out=100, go one cycle, dead=0.
- Ticks on consecutive cycles T and T+1 -> exactly one move and one go; enable=0 with a tick -> no change.
- Assert resetn during S_DRAW -> go=0 that cycle; outputs return to reset values asynchronously.
